asyn_controller: RTL and testbench
==================================

ASYN_CONTROLLER -- requirements
Module: asyn_controller

Interface
REQ-001 Parameters: none.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; overrides all other inputs.
REQ-005 set  input  1  start strobe; sampled on the rising edge of clk.
REQ-006 opcode  input  7  RISC-V major opcode of the instruction to sequence; captured with an accepted set.
REQ-007 req1  output  1  fetch-stage request.
REQ-008 req2_1  output  1  decode/rs1-read request.
REQ-009 req2_2  output  1  rs2-read request.
REQ-010 req3  output  1  execute-stage request.
REQ-011 req4  output  1  memory/write-back request.

Function
REQ-012 All outputs SHALL be registered and Moore-decoded from state and the captured opcode (no combinational path from inputs).
REQ-013 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB.
REQ-014 IDLE with set=1 SHALL capture opcode into an internal register and move to FETCH; set=0 stays in IDLE.
REQ-015 set SHALL be ignored in every state other than IDLE; opcode changes after capture SHALL NOT affect the sequence in progress.
REQ-016 FETCH SHALL assert req1 only, for one cycle, then go to DECODE.
REQ-017 DECODE SHALL last one cycle, then go to EXEC:
  - req2_1 = 1 for opcodes using rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - req2_2 = 1 for opcodes using rs2: 0110011, 0100011, 1100011.
  - LUI 0110111, AUIPC 0010111 and JAL 1101111 assert neither.
REQ-018 EXEC SHALL assert req3 only, for one cycle; next state:
  - Branch 1100011 -> IDLE.
  - Load 0000011 -> MEM.
  - All other legal opcodes -> WB.
REQ-019 MEM (load only) SHALL assert req4 for one cycle, then go to WB.
REQ-020 WB SHALL assert req4 for one cycle, then go to IDLE; a load therefore holds req4 for two consecutive cycles.
REQ-021 Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
REQ-022 Any other opcode SHALL produce FETCH (req1 for one cycle), then return directly to IDLE with no req2_x/req3/req4.
REQ-023 At most one of {req1, req2_x, req3, req4} groups SHALL be active in any cycle; all outputs SHALL be 0 in IDLE.
REQ-024 Latency: set accepted at edge N gives req1 in cycle N+1, DECODE in N+2, req3 in N+3, req4 in N+4 (and N+5 for load).
REQ-025 Back-to-back: after the final state the FSM SHALL spend at least one cycle in IDLE before accepting a new set.
REQ-026 If set stays high continuously, a new instruction SHALL be accepted on each IDLE cycle.

Reset
REQ-027 reset=1 at a rising edge SHALL force state IDLE, clear the captured opcode to 0000000, and drive all five outputs to 0 in the following cycle.
REQ-028 reset SHALL take priority over a simultaneous set, so no capture occurs.
REQ-029 reset asserted mid-sequence SHALL abort the sequence immediately, with no further req pulses.

Verification
REQ-030 reset=1, set=0, opcode=1100011 for 5 cycles -> all outputs 0, FSM in IDLE.
REQ-031 reset=0, one-cycle set with opcode=0110011 -> req1, then req2_1=req2_2=1, then req3, then req4, one cycle each, then all 0.
REQ-032 set with opcode=1100011 (branch) -> req1; req2_1=req2_2=1; req3; then IDLE with req4 never asserted.
REQ-033 set with opcode=0000011 (load) -> req1; req2_1 only; req3; req4 for 2 cycles; then IDLE.
REQ-034 set with opcode=0110111 (LUI) -> req1; DECODE cycle with all outputs 0; req3; req4.
REQ-035 Illegal opcode 1111111 -> req1 for one cycle, then IDLE.
REQ-036 set toggled and opcode changed mid-sequence -> sequence unchanged.
REQ-037 reset pulsed during EXEC -> all outputs 0 from the next cycle.

Source files
------------

// File: rtl/asyn_controller_if.sv
// ----------------------------------------------------------------------------
// asyn_controller_if
// Handshake bundle between an instruction issuer and the asyn_controller
// sequencer.
//   set     : start strobe from the issuer
//   opcode  : 7-bit RISC-V major opcode, captured with an accepted set
//   req1    : fetch-stage request
//   req2_1  : decode / rs1-read request
//   req2_2  : rs2-read request
//   req3    : execute-stage request
//   req4    : memory / write-back request
// master = issuer side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface asyn_controller_if;
   logic       set;
   logic [6:0] opcode;
   logic       req1;
   logic       req2_1;
   logic       req2_2;
   logic       req3;
   logic       req4;

   modport master (
      output set, opcode,
      input  req1, req2_1, req2_2, req3, req4
   );

   modport slave (
      input  set, opcode,
      output req1, req2_1, req2_2, req3, req4
   );
endinterface

// File: rtl/asyn_controller.sv
// ----------------------------------------------------------------------------
// asyn_controller
// Sequences one RISC-V instruction through FETCH, DECODE, EXEC, MEM and WB,
// raising a single-cycle request strobe for each pipeline stage it visits.
// Ports:
//   clk   : system clock, all state changes on its rising edge
//   reset : synchronous active-high reset, overrides every other input
//   bus   : asyn_controller_if.slave (set/opcode in, req1..req4 out)
// All request outputs are flops decoded from the next state, so a strobe
// appears in the same cycle as the state it belongs to and never depends
// combinationally on the inputs.
// ----------------------------------------------------------------------------
module asyn_controller (
   input  logic                     clk,
   input  logic                     reset,
   asyn_controller_if.slave         bus
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5
   } state_t;

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs1(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: return 1'b1;
         default:                                           return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      case (op)
         OP_R, OP_STORE, OP_BRANCH: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

   state_t     state_q, state_d;
   logic [6:0] opcode_q, opcode_d;
   // Request vector order: {req1, req2_1, req2_2, req3, req4}
   logic [4:0] req_q, req_d;

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      case (state_q)
         IDLE: begin
            if (bus.set) begin
               opcode_d = bus.opcode;
               state_d  = FETCH;
            end
         end
         // An illegal opcode is only fetched; it never reaches decode.
         FETCH:  state_d = is_legal(opcode_q) ? DECODE : IDLE;
         DECODE: state_d = EXEC;
         EXEC: begin
            if (opcode_q == OP_BRANCH)
               state_d = IDLE;
            else if (opcode_q == OP_LOAD)
               state_d = MEM;
            else
               state_d = WB;
         end
         MEM:     state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Decode the strobes from where the FSM is going so the registered
      // outputs line up with the registered state.
      req_d = 5'b00000;
      case (state_d)
         FETCH:   req_d[4] = 1'b1;
         DECODE: begin
            req_d[3] = uses_rs1(opcode_d);
            req_d[2] = uses_rs2(opcode_d);
         end
         EXEC:    req_d[1] = 1'b1;
         MEM, WB: req_d[0] = 1'b1;
         default: req_d    = 5'b00000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         opcode_q <= 7'b0000000;
         req_q    <= 5'b00000;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         req_q    <= req_d;
      end
   end

   assign bus.req1   = req_q[4];
   assign bus.req2_1 = req_q[3];
   assign bus.req2_2 = req_q[2];
   assign bus.req3   = req_q[1];
   assign bus.req4   = req_q[0];

endmodule

// File: tb/tb_asyn_controller.sv
// ----------------------------------------------------------------------------
// tb_asyn_controller
// Directed bench for asyn_controller. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle away from the active
// rising edge. Observed vector order: {req1, req2_1, req2_2, req3, req4}.
// ----------------------------------------------------------------------------
module tb_asyn_controller;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   asyn_controller_if bus ();

   asyn_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] obs;
   assign obs = {bus.req1, bus.req2_1, bus.req2_2, bus.req3, bus.req4};

   // Reset held with a branch opcode on the bus, then reset against set.
   task automatic test_reset();
      reset      = 1'b1;
      bus.set    = 1'b0;
      bus.opcode = 7'b1100011;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs, 5'b00000);
         end
      end
      // set together with reset must not be captured
      bus.set    = 1'b1;
      bus.opcode = 7'b0110011;
      @(negedge clk);
      reset   = 1'b0;
      bus.set = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL reset_vs_set cyc=%0d got=%b exp=%b", i, obs, 5'b00000);
         end
      end
      $display("test_reset done");
   endtask

   // One instruction per table row, six sampled cycles after the accept edge.
   task automatic test_sequences();
      logic [6:0] ops [10];
      logic [4:0] exp_tab [10][6];
      ops = '{7'b0110011, 7'b1100011, 7'b0000011, 7'b0110111, 7'b1111111,
              7'b1101111, 7'b0100011, 7'b0010011, 7'b0010111, 7'b1100111};
      exp_tab = '{
         '{5'b10000, 5'b01100, 5'b00010, 5'b00001, 5'b00000, 5'b00000}, // R
         '{5'b10000, 5'b01100, 5'b00010, 5'b00000, 5'b00000, 5'b00000}, // branch
         '{5'b10000, 5'b01000, 5'b00010, 5'b00001, 5'b00001, 5'b00000}, // load
         '{5'b10000, 5'b00000, 5'b00010, 5'b00001, 5'b00000, 5'b00000}, // LUI
         '{5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000}, // illegal
         '{5'b10000, 5'b00000, 5'b00010, 5'b00001, 5'b00000, 5'b00000}, // JAL
         '{5'b10000, 5'b01100, 5'b00010, 5'b00001, 5'b00000, 5'b00000}, // store
         '{5'b10000, 5'b01000, 5'b00010, 5'b00001, 5'b00000, 5'b00000}, // I
         '{5'b10000, 5'b00000, 5'b00010, 5'b00001, 5'b00000, 5'b00000}, // AUIPC
         '{5'b10000, 5'b01000, 5'b00010, 5'b00001, 5'b00000, 5'b00000}  // JALR
      };
      for (int t = 0; t < 10; t++) begin
         int errs;
         errs       = 0;
         bus.set    = 1'b1;
         bus.opcode = ops[t];
         @(negedge clk);
         bus.set    = 1'b0;
         bus.opcode = 7'b0000000;
         for (int c = 0; c < 6; c++) begin
            checks++;
            if (obs !== exp_tab[t][c]) begin
               failures++;
               errs++;
               $display("FAIL seq op=%b cyc=%0d got=%b exp=%b", ops[t], c, obs, exp_tab[t][c]);
            end
            @(negedge clk);
         end
         $display("test_sequences op=%b errors=%0d", ops[t], errs);
      end
   endtask

   // set toggling and opcode changing while an R-type is in flight.
   task automatic test_mid_change();
      logic [4:0] exp_seq [6];
      exp_seq = '{5'b10000, 5'b01100, 5'b00010, 5'b00001, 5'b00000, 5'b00000};
      bus.set    = 1'b1;
      bus.opcode = 7'b0110011;
      @(negedge clk);
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (obs !== exp_seq[c]) begin
            failures++;
            $display("FAIL mid_change cyc=%0d got=%b exp=%b", c, obs, exp_seq[c]);
         end
         // The last edge before IDLE is the WB->IDLE edge (after sample 3);
         // set must be low once the FSM is back in IDLE.
         bus.set    = (c <= 3) ? ((c % 2) == 0) : 1'b0;
         bus.opcode = (c % 2 == 0) ? 7'b0000011 : 7'b1111111;
         @(negedge clk);
      end
      bus.opcode = 7'b0000000;
      $display("test_mid_change done");
   endtask

   // Reset pulsed while the FSM is in EXEC for a load.
   task automatic test_reset_mid();
      logic [4:0] exp_seq [3];
      exp_seq = '{5'b10000, 5'b01000, 5'b00010};
      bus.set    = 1'b1;
      bus.opcode = 7'b0000011;
      @(negedge clk);
      bus.set = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (obs !== exp_seq[c]) begin
            failures++;
            $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", c, obs, exp_seq[c]);
         end
         if (c < 2) @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL reset_mid_post cyc=%0d got=%b exp=%b", c, obs, 5'b00000);
         end
         @(negedge clk);
      end
      $display("test_reset_mid done");
   endtask

   // set held high: each IDLE cycle accepts a new LUI.
   task automatic test_back_to_back();
      logic [4:0] exp_seq [10];
      exp_seq = '{5'b10000, 5'b00000, 5'b00010, 5'b00001, 5'b00000,
                  5'b10000, 5'b00000, 5'b00010, 5'b00001, 5'b00000};
      bus.set    = 1'b1;
      bus.opcode = 7'b0110111;
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (obs !== exp_seq[c]) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, obs, exp_seq[c]);
         end
         if (c == 8) bus.set = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (obs !== 5'b00000) begin
         failures++;
         $display("FAIL back_to_back_tail got=%b exp=%b", obs, 5'b00000);
      end
      $display("test_back_to_back done");
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset      = 1'b1;
      bus.set    = 1'b0;
      bus.opcode = 7'b0000000;
      test_reset();
      test_sequences();
      test_mid_change();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
